// File: rtl/reg_bank_wb.sv
// 32 x DATA_W register bank: synchronous write, combinational reads with write-through bypass.
// Register 0 reads as zero; register 29 (stack pointer) resets to SP_RESET.
module reg_bank_wb #(
    parameter int          DATA_W   = 32,
    parameter int unsigned SP_RESET = 227
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [4:0]        ReadReg1,
    input  logic [4:0]        ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2
);

    localparam logic [DATA_W-1:0] SP_RESET_W = DATA_W'(SP_RESET);
    localparam logic [4:0]        SP_IDX     = 5'd29;

    logic [DATA_W-1:0] regs_q [32];
    logic [DATA_W-1:0] rd1_d;
    logic [DATA_W-1:0] rd2_d;
    logic              wr_en;

    // Reset blocks both the array write and the bypass path
    assign wr_en = RegWrite && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (5'(i) == SP_IDX) ? SP_RESET_W : '0;
            end
        end else if (wr_en && (WriteReg != 5'd0)) begin
            regs_q[WriteReg] <= WriteData;
        end
    end

    always_comb begin
        rd1_d = regs_q[ReadReg1];
        if (ReadReg1 == 5'd0) begin
            rd1_d = '0;
        end else if (wr_en && (WriteReg == ReadReg1)) begin
            rd1_d = WriteData;
        end
    end

    always_comb begin
        rd2_d = regs_q[ReadReg2];
        if (ReadReg2 == 5'd0) begin
            rd2_d = '0;
        end else if (wr_en && (WriteReg == ReadReg2)) begin
            rd2_d = WriteData;
        end
    end

    assign ReadData1 = rd1_d;
    assign ReadData2 = rd2_d;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Self-checking bench for reg_bank_wb: vector table plus hand-written reset sequences,
// expectations queued when stimulus is driven and compared once outputs settle.
module tb_reg_bank_wb;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteReg = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadReg1 = '0;
    logic [4:0]  ReadReg2 = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int checks = 0;
    int failures = 0;

    reg_bank_wb #(.DATA_W(32), .SP_RESET(227)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb_q[$];

    task automatic push_exp(input string name, input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        e.name = name;
        e.e1 = e1;
        e.e2 = e2;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (ReadData1 !== e.e1) begin
            failures++;
            $display("FAIL %s port1: got %h expected %h", e.name, ReadData1, e.e1);
        end
        checks++;
        if (ReadData2 !== e.e2) begin
            failures++;
            $display("FAIL %s port2: got %h expected %h", e.name, ReadData2, e.e2);
        end
    endtask

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2);
        RegWrite  = rw;
        WriteReg  = wr;
        WriteData = wd;
        ReadReg1  = r1;
        ReadReg2  = r2;
    endtask

    vec_t vecs[15];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd8,  32'hDEADBEEF, 5'd8,  5'd8,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 5'd31, 32'h00000005, 5'd8,  5'd31, 32'hDEADBEEF, 32'h00000005};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        5'd8,  5'd31, 32'hDEADBEEF, 32'h00000005};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,        32'h0};
        vecs[5]  = '{1'b1, 5'd12, 32'h00001234, 5'd12, 5'd12, 32'h00001234, 32'h00001234};
        vecs[6]  = '{1'b0, 5'd12, 32'h00009999, 5'd12, 5'd8,  32'h00001234, 32'hDEADBEEF};
        vecs[7]  = '{1'b0, 5'd29, 32'h0000AAAA, 5'd29, 5'd29, 32'd227,      32'd227};
        vecs[8]  = '{1'b0, 5'd29, 32'h0000AAAA, 5'd29, 5'd29, 32'd227,      32'd227};
        vecs[9]  = '{1'b0, 5'd29, 32'h0000AAAA, 5'd29, 5'd29, 32'd227,      32'd227};
        vecs[10] = '{1'b1, 5'd29, 32'h00000100, 5'd29, 5'd0,  32'h00000100, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        5'd29, 5'd12, 32'h00000100, 32'h00001234};
        vecs[12] = '{1'b1, 5'd5,  32'h0000000A, 5'd5,  5'd6,  32'h0000000A, 32'h0};
        vecs[13] = '{1'b1, 5'd5,  32'h0000000B, 5'd5,  5'd5,  32'h0000000B, 32'h0000000B};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h0000000B, 32'h00000005};

        // Reset pulse entirely between clock edges (first rising edge is at t=5)
        #2;
        Reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd1);
        push_exp("reset_r0_r1", 32'h0, 32'h0);
        #1;
        pop_check();
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd31);
        push_exp("reset_r29_r31", 32'd227, 32'h0);
        #0.5;
        pop_check();
        #0.5;
        Reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge Clk);
            drive(vecs[i].rw, vecs[i].wr, vecs[i].wd, vecs[i].r1, vecs[i].r2);
            push_exp($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
            #1;
            pop_check();
        end

        // Reset asserted on top of a pending write to reg 3
        @(negedge Clk);
        drive(1'b1, 5'd3, 32'h55, 5'd3, 5'd29);
        push_exp("mid_pre_bypass", 32'h55, 32'h00000100);
        #1;
        pop_check();
        @(negedge Clk);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd29);
        push_exp("mid_pre_stored", 32'h55, 32'h00000100);
        #1;
        pop_check();
        @(negedge Clk);
        drive(1'b1, 5'd3, 32'h77, 5'd3, 5'd29);
        #1;
        Reset = 1'b1;
        push_exp("mid_reset_async", 32'h0, 32'd227);
        #1;
        pop_check();
        @(negedge Clk);
        push_exp("mid_reset_held_over_edge", 32'h0, 32'd227);
        #1;
        pop_check();
        @(negedge Clk);
        Reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd29);
        push_exp("post_reset_r3_r29", 32'h0, 32'd227);
        #1;
        pop_check();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd31);
        push_exp("post_reset_r8_r31", 32'h0, 32'h0);
        #1;
        pop_check();
        @(negedge Clk);
        drive(1'b1, 5'd3, 32'h88, 5'd3, 5'd29);
        push_exp("post_reset_write_bypass", 32'h88, 32'd227);
        #1;
        pop_check();
        @(negedge Clk);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
        push_exp("post_reset_write_stored", 32'h88, 32'h88);
        #1;
        pop_check();

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
